// File: rtl/mem_port_arbiter_if.sv
// Bundles the requester-side (IF, LS) and memory-side signals of the unified
// memory port arbiter. The slave view is taken by the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BW = DW / 8;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [BW-1:0] ls_be;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;

    logic          err;
    logic          busy;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output err, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  err, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store: LS has
// priority, a streak limit guarantees IF progress, a timer aborts hung accesses.
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_LS_STREAK = 3,
    parameter int TIMEOUT       = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    localparam int BW = DW / 8;
    localparam int SW = (MAX_LS_STREAK > 0) ? $clog2(MAX_LS_STREAK + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic [TW-1:0] r_timer;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [BW-1:0] r_mem_be;
    logic          r_if_rvalid;
    logic          r_ls_rvalid;
    logic          r_err;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_ls_rdata;

    logic w_idle;
    logic w_if_force;
    logic w_ls_gnt;
    logic w_if_gnt;
    logic w_timeout;

    // Grants are qualified by reset so an asserted reset silences them at once.
    assign w_idle     = (r_state == ST_IDLE) && reset;
    assign w_if_force = bus.if_req && (r_streak == SW'(MAX_LS_STREAK));
    assign w_ls_gnt   = w_idle && bus.ls_req && !w_if_force;
    assign w_if_gnt   = w_idle && bus.if_req && !w_ls_gnt;
    assign w_timeout  = (TIMEOUT > 0) && (r_timer == TW'(TIMEOUT - 1)) && !bus.mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_streak    <= '0;
            r_timer     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (w_ls_gnt) begin
                        r_state     <= ST_BUSY_LS;
                        r_mem_we    <= bus.ls_we;
                        r_mem_addr  <= bus.ls_addr;
                        r_mem_wdata <= bus.ls_wdata;
                        r_mem_be    <= bus.ls_be;
                        if (!bus.if_req) begin
                            r_streak <= '0;
                        end else if (r_streak != SW'(MAX_LS_STREAK)) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end else if (w_if_gnt) begin
                        r_state     <= ST_BUSY_IF;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= bus.if_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '1;
                        r_streak    <= '0;
                    end
                end
                ST_BUSY_IF, ST_BUSY_LS: begin
                    if (bus.mem_ready) begin
                        r_state <= ST_IDLE;
                        if (r_state == ST_BUSY_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= bus.mem_rdata;
                        end else begin
                            r_ls_rvalid <= 1'b1;
                            // Write acks leave the last read data in place.
                            if (!r_mem_we) begin
                                r_ls_rdata <= bus.mem_rdata;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                        if (r_state == ST_BUSY_IF) begin
                            r_if_rvalid <= 1'b1;
                        end else begin
                            r_ls_rvalid <= 1'b1;
                        end
                    end else if (TIMEOUT > 0) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.ls_gnt    = w_ls_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.ls_rvalid = r_ls_rvalid;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.mem_req   = (r_state != ST_IDLE);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter; the bench plays both
// requesters and the memory, and predicts responses from the arbitration rules.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 3;
    localparam int TO  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_LS_STREAK(MAX), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_ls_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access from an idle arbiter with no competing request.
    task automatic access(input bit is_ls, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int waits, input logic [31:0] rdata);
        if (is_ls) begin
            bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = addr;
            bus.ls_wdata = wdata; bus.ls_be = be;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        #1;
        chk("gnt_winner", is_ls ? bus.ls_gnt : bus.if_gnt, 1);
        chk("gnt_other", is_ls ? bus.if_gnt : bus.ls_gnt, 0);
        tick();
        bus.ls_req = 1'b0; bus.if_req = 1'b0;
        bus.ls_addr = $urandom; bus.if_addr = $urandom;
        bus.ls_wdata = $urandom; bus.ls_be = 4'($urandom); bus.ls_we = 1'($urandom);
        chk("mem_req_busy", {bus.mem_req, bus.busy}, 2'b11);
        chk("mem_addr", bus.mem_addr, addr);
        chk("mem_we", bus.mem_we, is_ls ? we : 1'b0);
        chk("mem_be", bus.mem_be, is_ls ? be : 4'hF);
        if (is_ls && we) chk("mem_wdata", bus.mem_wdata, wdata);
        for (int i = 0; i < waits; i++) begin
            bus.mem_rdata = $urandom;
            tick();
            chk("addr_hold", {bus.mem_req, bus.mem_addr}, {1'b1, addr});
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = rdata;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rdata = $urandom;
        if (is_ls && !we) exp_ls_rdata = rdata;
        if (!is_ls) exp_if_rdata = rdata;
        chk("rvalid", {bus.if_rvalid, bus.ls_rvalid}, is_ls ? 2'b01 : 2'b10);
        chk("err_busy_req", {bus.err, bus.busy, bus.mem_req}, 3'b000);
        chk("if_rdata", bus.if_rdata, exp_if_rdata);
        chk("ls_rdata", bus.ls_rdata, exp_ls_rdata);
        tick();
        chk("rvalid_pulse", {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
        $display("txn %s we=%0d addr=%08h waits=%0d rdata=%08h", is_ls ? "LS" : "IF",
                 we, addr, waits, rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.if_req = 1'b1; bus.if_addr = '0;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = '0;
        bus.ls_wdata = '0; bus.ls_be = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;

        // Reset state, with both requests held to show grants are gated.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", {bus.if_gnt, bus.ls_gnt}, 2'b00);
        chk("rst_ctrl", {bus.mem_req, bus.busy, bus.if_rvalid, bus.ls_rvalid, bus.err}, 5'b0);
        chk("rst_data", {bus.mem_addr, bus.if_rdata}, 64'h0);
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        $display("txn reset released");

        // IF read of 0x100 completing in the first busy cycle.
        access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hDEADBEEF);

        // Simultaneous requests: LS write first, IF granted in the ack cycle.
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h300;
        bus.ls_wdata = 32'hCAFEF00D; bus.ls_be = 4'b0011;
        #1;
        chk("both_gnt", {bus.ls_gnt, bus.if_gnt}, 2'b10);
        tick();
        bus.ls_req = 1'b0;
        chk("wr_fields", {bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b1, 4'b0011, 32'h300});
        chk("wr_wdata", bus.mem_wdata, 32'hCAFEF00D);
        chk("busy_no_gnt", {bus.ls_gnt, bus.if_gnt}, 2'b00);
        bus.mem_ready = 1'b1; bus.mem_rdata = $urandom;
        tick();
        bus.mem_ready = 1'b0;
        chk("wr_ack", {bus.ls_rvalid, bus.if_gnt}, 2'b11);
        chk("wr_ack_rdata", bus.ls_rdata, exp_ls_rdata);
        tick();
        bus.if_req = 1'b0;
        chk("if_after_ls", {bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b0, 4'hF, 32'h200});
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_ready = 1'b0;
        exp_if_rdata = 32'h12345678;
        chk("if_after_ls_rd", {bus.if_rvalid, bus.if_rdata}, {1'b1, exp_if_rdata});
        $display("txn LS write + IF read contention");
        tick();

        // Both held: grant pattern repeats MAX LS grants then one IF grant.
        bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.ls_we = 1'b0;
        for (int g = 0; g < 12; g++) begin
            bit exp_ls;
            logic [31:0] d;
            exp_ls = (g % (MAX + 1)) != MAX;
            bus.if_addr = $urandom; bus.ls_addr = $urandom;
            #1;
            chk("streak_order", {bus.ls_gnt, bus.if_gnt}, {exp_ls, !exp_ls});
            tick();
            repeat ($urandom_range(0, 3)) tick();
            d = $urandom;
            bus.mem_ready = 1'b1; bus.mem_rdata = d;
            tick();
            bus.mem_ready = 1'b0;
            if (exp_ls) exp_ls_rdata = d; else exp_if_rdata = d;
            chk("streak_rvalid", {bus.ls_rvalid, bus.if_rvalid}, {exp_ls, !exp_ls});
            chk("streak_rdata", exp_ls ? bus.ls_rdata : bus.if_rdata, d);
            $display("txn streak grant %0d %s", g, exp_ls ? "LS" : "IF");
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        tick();

        // Timeout on an LS read that never sees mem_ready.
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h500;
        #1;
        chk("to_gnt", bus.ls_gnt, 1);
        tick();
        bus.ls_req = 1'b0;
        cnt = 0;
        while (bus.mem_req === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("to_req_cycles", cnt, TO);
        chk("to_pulse", {bus.ls_rvalid, bus.err, bus.busy}, 3'b110);
        chk("to_rdata", bus.ls_rdata, exp_ls_rdata);
        tick();
        chk("to_after", {bus.ls_rvalid, bus.err, bus.busy}, 3'b000);
        $display("txn LS timeout after %0d cycles", cnt);

        // Asynchronous reset in the middle of an IF access.
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        #1;
        chk("rst_mid_gnt", bus.if_gnt, 1);
        tick();
        chk("rst_mid_busy", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_drop", {bus.mem_req, bus.busy, bus.if_gnt}, 3'b000);
        bus.mem_ready = 1'b1;
        tick();
        bus.if_req = 1'b0; bus.mem_ready = 1'b0;
        #2 rst_n = 1'b1;
        exp_if_rdata = '0; exp_ls_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_rvalid", {bus.if_rvalid, bus.busy}, 2'b00);
        end
        $display("txn reset mid IF access");
        access(1'b0, 1'b0, 32'h404, 32'h0, 4'h0, 1, 32'hA5A5_0001);

        // mem_ready in IDLE produces nothing.
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("idle_ready", {bus.if_rvalid, bus.ls_rvalid, bus.busy}, 3'b000);

        // LS read with five wait cycles and mem_rdata toggling.
        access(1'b1, 1'b0, 32'h0000_0ABC, 32'h0, 4'hF, 5, 32'h0BAD_F00D);

        // Randomized single accesses.
        for (int n = 0; n < 16; n++) begin
            bit is_ls;
            is_ls = 1'($urandom);
            access(is_ls, is_ls ? 1'($urandom) : 1'b0, $urandom, $urandom,
                   4'($urandom), $urandom_range(0, 6), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
